ogpu_raster_clip_filter: RTL and testbench

//   Scissor stage of the raster unit: consumes the clip_rect0/clip_rect1 PIO register outputs.

---
 rtl/ogpu_raster_pkg.sv | 30 +++
 rtl/ogpu_clip_cmp.sv | 24 ++
 rtl/ogpu_raster_clip_filter.sv | 162 ++++++++++++++++
 tb/tb_ogpu_raster_clip_filter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ogpu_raster_pkg.sv
// Shared raster-unit types: clip rectangle layout, its pass-all reset value and
// the helper that unpacks the two 32-bit PIO words into a rectangle.
package ogpu_raster_pkg;

  typedef struct packed {
    logic [15:0] xmin;
    logic [15:0] ymin;
    logic [15:0] xmax;
    logic [15:0] ymax;
  } clip_rect_t;

  localparam clip_rect_t CLIP_RECT_RESET = '{
    xmin: 16'h0000,
    ymin: 16'h0000,
    xmax: 16'hFFFF,
    ymax: 16'hFFFF
  };

  // r0 = {ymin, xmin}, r1 = {ymax, xmax}; max bounds are inclusive.
  function automatic clip_rect_t unpack_clip_rect(input logic [31:0] r0,
                                                  input logic [31:0] r1);
    clip_rect_t r;
    r.xmin = r0[15:0];
    r.ymin = r0[31:16];
    r.xmax = r1[15:0];
    r.ymax = r1[31:16];
    return r;
  endfunction

endpackage

// File: rtl/ogpu_clip_cmp.sv
// Combinational inside test of a fragment against an inclusive rectangle.
// An inverted rectangle (min > max on either axis) contains no point.
module ogpu_clip_cmp
  import ogpu_raster_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  clip_rect_t         rect_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               inside_o
);

  logic [15:0] x_ext;
  logic [15:0] y_ext;

  // Coordinates narrower than the register field are zero-extended.
  assign x_ext = 16'(x_i);
  assign y_ext = 16'(y_i);

  assign inside_o = (x_ext >= rect_i.xmin) && (x_ext <= rect_i.xmax) &&
                    (y_ext >= rect_i.ymin) && (y_ext <= rect_i.ymax);

endmodule

// File: rtl/ogpu_raster_clip_filter.sv
// Scissor stage: drops fragments outside the shadowed clip rectangle, passes the rest.
// Optional hit/miss counters are built when OGPU_CLIP_STATS_EN is defined.
module ogpu_raster_clip_filter
  import ogpu_raster_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef OGPU_CLIP_STATS_EN
  input  logic               stats_clr,
  output logic [31:0]        pass_count,
  output logic [31:0]        drop_count,
`endif
  input  logic [31:0]        clip_rect0,
  input  logic [31:0]        clip_rect1,
  input  logic               rect_load,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               prim_done
);

  clip_rect_t rect_q;

  logic               inside_p0;
  logic               accept_p0;

  logic               vld_p1_q;
  logic               inside_p1_q;
  logic               last_p1_q;
  logic [COORD_W-1:0] x_p1_q;
  logic [COORD_W-1:0] y_p1_q;
  logic [DATA_W-1:0]  data_p1_q;
  logic               retire_p1;
  logic               pass_p1;

  logic               vld_p2_q;
  logic               last_p2_q;
  logic [COORD_W-1:0] x_p2_q;
  logic [COORD_W-1:0] y_p2_q;
  logic [DATA_W-1:0]  data_p2_q;
  logic               load_ok_p2;

  // Shadow rectangle; a same-cycle acceptance still sees the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rect_q <= CLIP_RECT_RESET;
    end else if (rect_load) begin
      rect_q <= unpack_clip_rect(clip_rect0, clip_rect1);
    end
  end

  ogpu_clip_cmp #(
    .COORD_W (COORD_W)
  ) u_cmp (
    .rect_i   (rect_q),
    .x_i      (in_x),
    .y_i      (in_y),
    .inside_o (inside_p0)
  );

  assign load_ok_p2 = !vld_p2_q || out_ready;
  assign retire_p1  = vld_p1_q && (!inside_p1_q || load_ok_p2);
  assign pass_p1    = retire_p1 && inside_p1_q;
  assign in_ready   = !vld_p1_q || retire_p1;
  assign accept_p0  = in_valid && in_ready;
  assign prim_done  = retire_p1 && last_p1_q;

  // ---- S1: capture fragment and its verdict ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q    <= 1'b0;
      inside_p1_q <= 1'b0;
      last_p1_q   <= 1'b0;
    end else if (accept_p0) begin
      vld_p1_q    <= 1'b1;
      inside_p1_q <= inside_p0;
      last_p1_q   <= in_last;
    end else if (retire_p1) begin
      vld_p1_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      x_p1_q    <= in_x;
      y_p1_q    <= in_y;
      data_p1_q <= in_data;
    end
  end

  // ---- S2: output register, held while downstream stalls ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      x_p2_q    <= '0;
      y_p2_q    <= '0;
      data_p2_q <= '0;
    end else if (load_ok_p2) begin
      vld_p2_q <= pass_p1;
      if (pass_p1) begin
        last_p2_q <= last_p1_q;
        x_p2_q    <= x_p1_q;
        y_p2_q    <= y_p1_q;
        data_p2_q <= data_p1_q;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_last  = last_p2_q;
  assign out_x     = x_p2_q;
  assign out_y     = y_p2_q;
  assign out_data  = data_p2_q;

`ifdef OGPU_CLIP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] pass_cnt_q, pass_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (stats_clr) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end else if (retire_p1) begin
      if (inside_p1_q) pass_cnt_d = sat_inc(pass_cnt_q);
      else             drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pass_count = pass_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ogpu_raster_clip_filter.sv
// Bench for the scissor stage: directed scenarios plus a randomized phase, scored
// against a queue-based model of which fragments must come out and in what order.
module tb_ogpu_raster_clip_filter;

  localparam int DATA_W  = 32;
  localparam int COORD_W = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [31:0]        clip_rect0 = '0;
  logic [31:0]        clip_rect1 = '0;
  logic               rect_load = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [COORD_W-1:0] in_x = '0;
  logic [COORD_W-1:0] in_y = '0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [DATA_W-1:0]  out_data;
  logic               out_last;
  logic               prim_done;
`ifdef OGPU_CLIP_STATS_EN
  logic               stats_clr = 1'b0;
  logic [31:0]        pass_count;
  logic [31:0]        drop_count;
`endif

  ogpu_raster_clip_filter #(
    .DATA_W  (DATA_W),
    .COORD_W (COORD_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef OGPU_CLIP_STATS_EN
    .stats_clr  (stats_clr),
    .pass_count (pass_count),
    .drop_count (drop_count),
`endif
    .clip_rect0 (clip_rect0),
    .clip_rect1 (clip_rect1),
    .rect_load  (rect_load),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_data   (out_data),
    .out_last   (out_last),
    .prim_done  (prim_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] d;
    logic        l;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   pd_seen = 0;
  int   pd_exp = 0;
  int   m_pass = 0;
  int   m_drop = 0;
  int   exp_rdy = -1;
  bit   strict_lat = 0;
  bit   hold_pending = 0;
  logic [15:0] hx, hy;
  logic [31:0] hd;
  logic        hl;
  int   mxmin = 0, mymin = 0, mxmax = 65535, mymax = 65535;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, update the model, return just after the rising edge.
  task automatic step();
    exp_t e;
    int   x, y;
    bit   ins;
    @(negedge clk);
    cyc++;
    if (hold_pending) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_x", out_x, hx);
      chk("hold_y", out_y, hy);
      chk("hold_data", out_data, hd);
      chk("hold_last", out_last, hl);
    end
    if (exp_rdy >= 0) chk("in_ready", in_ready, exp_rdy[0]);
    if (out_valid && expq.size() == 0) chk("spurious_out_valid", out_valid, 0);
    if (out_valid && out_ready && expq.size() != 0) begin
      e = expq.pop_front();
      out_cnt++;
      chk("out_x", out_x, e.x);
      chk("out_y", out_y, e.y);
      chk("out_data", out_data, e.d);
      chk("out_last", out_last, e.l);
      if (strict_lat) chk("latency", cyc - e.acc, 2);
    end
    hold_pending = out_valid && !out_ready;
    hx = out_x; hy = out_y; hd = out_data; hl = out_last;
    if (prim_done) pd_seen++;
`ifdef OGPU_CLIP_STATS_EN
    if (stats_clr) begin
      m_pass = 0;
      m_drop = 0;
    end
`endif
    if (in_valid && in_ready) begin
      x = int'(in_x);
      y = int'(in_y);
      ins = (x >= mxmin) && (x <= mxmax) && (y >= mymin) && (y <= mymax);
      if (ins) begin
        e.x = in_x; e.y = in_y; e.d = in_data; e.l = in_last; e.acc = cyc;
        expq.push_back(e);
        m_pass++;
      end else begin
        m_drop++;
      end
      if (in_last) pd_exp++;
    end
    if (rect_load) begin
      mxmin = int'(clip_rect0[15:0]);
      mymin = int'(clip_rect0[31:16]);
      mxmax = int'(clip_rect1[15:0]);
      mymax = int'(clip_rect1[31:16]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_rect(input int x0, input int y0, input int x1, input int y1);
    clip_rect0 = {16'(y0), 16'(x0)};
    clip_rect1 = {16'(y1), 16'(x1)};
    rect_load  = 1'b1;
    in_valid   = 1'b0;
    step();
    rect_load  = 1'b0;
  endtask

  task automatic drive(input int x, input int y, input bit last);
    in_valid = 1'b1;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_data  = $urandom;
    in_last  = last;
  endtask

  task automatic chk_stats();
`ifdef OGPU_CLIP_STATS_EN
    chk("pass_count", pass_count, m_pass);
    chk("drop_count", drop_count, m_drop);
`endif
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    exp_rdy   = -1;
    for (int i = 0; i < 8; i++) step();
    chk({tag, "_queue_empty"}, expq.size(), 0);
    chk({tag, "_prim_done_count"}, pd_seen, pd_exp);
    chk_stats();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    rect_load = 1'b0;
    out_ready = 1'b1;
`ifdef OGPU_CLIP_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_prim_done", prim_done, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef OGPU_CLIP_STATS_EN
    chk("rst_pass_count", pass_count, 0);
    chk("rst_drop_count", drop_count, 0);
`endif
    expq.delete();
    mxmin = 0; mymin = 0; mxmax = 65535; mymax = 65535;
    hold_pending = 0;
    pd_seen = 0; pd_exp = 0; m_pass = 0; m_drop = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xs[5] = '{10, 30, 9, 31, 10};
    int ys[5] = '{20, 40, 20, 40, 41};
    int base, pd_before;

    #1;
    do_reset();

    // Scenario 1: edge fragments of rect (10,20)-(30,40)
    load_rect(10, 20, 30, 40);
    strict_lat = 1;
    exp_rdy = 1;
    base = out_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(xs[i], ys[i], 1'b0);
      step();
    end
    drain("t1");
    chk("t1_pass_count", out_cnt - base, 2);

    // Scenario 2: 100 back-to-back inside fragments
    exp_rdy = 1;
    base = out_cnt;
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(30, 10), $urandom_range(40, 20), 1'b0);
      step();
    end
    drain("t2");
    chk("t2_pass_count", out_cnt - base, 100);
    strict_lat = 0;

    // Scenario 3: downstream stall with S1 and S2 full
    out_ready = 1'b0;
    exp_rdy = 1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(30, 10), $urandom_range(40, 20), 1'b0);
      step();
    end
    drive(15, 25, 1'b0);
    exp_rdy = 0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    exp_rdy = -1;
    step();
    drain("t3");

    // Scenario 4: inverted rectangle drops everything, last still signals prim_done
    load_rect(50, 0, 40, 65535);
    pd_before = pd_seen;
    for (int i = 0; i < 8; i++) begin
      drive($urandom_range(60, 30), $urandom_range(100, 0), i == 7);
      step();
    end
    drain("t4");
    chk("t4_prim_done_pulses", pd_seen - pd_before, 1);

    // Scenario 5: rect_load in the acceptance cycle uses the old rectangle
    load_rect(0, 0, 65535, 65535);
    base = out_cnt;
    clip_rect0 = 32'h0;
    clip_rect1 = 32'h0;
    rect_load  = 1'b1;
    drive(5, 5, 1'b0);
    step();
    rect_load = 1'b0;
    drive(5, 5, 1'b0);
    step();
    drain("t5");
    chk("t5_pass_count", out_cnt - base, 1);

    // Randomized traffic with occasional rectangle changes and backpressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19, 0) == 0) begin
        clip_rect0 = {16'($urandom_range(40, 0)), 16'($urandom_range(40, 0))};
        clip_rect1 = {16'($urandom_range(63, 10)), 16'($urandom_range(63, 10))};
        rect_load  = 1'b1;
      end else begin
        rect_load  = 1'b0;
      end
      in_valid  = ($urandom_range(9, 0) < 7);
      in_x      = 16'($urandom_range(63, 0));
      in_y      = 16'($urandom_range(63, 0));
      in_data   = $urandom;
      in_last   = ($urandom_range(7, 0) == 0);
      out_ready = ($urandom_range(9, 0) < 6);
      step();
    end
    rect_load = 1'b0;
    drain("rand");

`ifdef OGPU_CLIP_STATS_EN
    // Scenario 6: counters, clear against a concurrent drop
    do_reset();
    load_rect(10, 20, 30, 40);
    for (int i = 0; i < 7; i++) begin
      if (i < 3) drive(12 + i, 22, 1'b0);
      else       drive(50 + i, 22, 1'b0);
      step();
    end
    drain("t6");
    chk("t6_pass_3", pass_count, 3);
    chk("t6_drop_4", drop_count, 4);
    drive(99, 99, 1'b0);
    step();
    in_valid  = 1'b0;
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    step();
    chk("t6_clr_pass", pass_count, 0);
    chk("t6_clr_drop", drop_count, 0);
    m_pass = 0;
    m_drop = 0;
`endif

    // Reset in the middle of a burst, then the rectangle must be pass-all again
    load_rect(10, 20, 30, 40);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(30, 10), $urandom_range(40, 20), i == 2);
      step();
    end
    do_reset();
    pd_before = pd_seen;
    base = out_cnt;
    drive(60000, 60000, 1'b1);
    step();
    drain("post_rst");
    chk("post_rst_pass", out_cnt - base, 1);
    chk("post_rst_prim_done", pd_seen - pd_before, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
